// File: rtl/pp3_dffepc_equiv_checker.sv
// pp3_dffepc_equiv_checker: drives pseudo-random D/EN into dffepc lanes and checks DUT_Q against a golden model.
// Define PP3_EQUIV_ASYNC_EN to also drive random CLR/PRE into the lanes.
module pp3_dffepc_equiv_checker #(
   parameter int          WIDTH       = 4,
   parameter int          NUM_VECTORS = 256,
   parameter logic [15:0] SEED        = 16'hACE1,
   parameter logic        INIT        = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   output logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] EN,
   output logic [WIDTH-1:0] CLR,
   output logic [WIDTH-1:0] PRE,
   input  logic [WIDTH-1:0] DUT_Q,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [15:0]      ERR_COUNT,
   output logic [15:0]      FIRST_ERR_IDX,
   output logic [WIDTH-1:0] FIRST_ERR_MASK
);
   localparam logic [2:0] S_IDLE = 3'd0, S_INIT = 3'd1, S_RUN = 3'd2, S_DRAIN = 3'd3, S_DONE = 3'd4;
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS);
   logic [2:0]       state;
   logic [15:0]      lfsr, lfsr_nx, idx;
   logic [WIDTH-1:0] g, g_nx, exp_q, mism, v_d, v_en;
   logic [2:0]       pop;
   logic [16:0]      err_sum;
   logic             start_run, load;
   assign BUSY      = (state == S_INIT) || (state == S_RUN) || (state == S_DRAIN);
   assign DONE      = state == S_DONE;
   assign PASS      = DONE && (ERR_COUNT == 16'h0000);
   assign start_run = START && ((state == S_IDLE) || (state == S_DONE));
   // A new vector is loaded on every INIT/RUN exit edge until the last index has been issued.
   assign load      = ((state == S_INIT) || (state == S_RUN)) && (idx != LAST_IDX);
   always_comb begin
      lfsr_nx = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      v_d     = '0;
      v_en    = '0;
      g_nx    = g;
      exp_q   = g;
      pop     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         v_d[i]   = lfsr_nx[i];
         v_en[i]  = lfsr_nx[4+i];
         g_nx[i]  = CLR[i] ? 1'b0 : PRE[i] ? 1'b1 : EN[i] ? D[i] : g[i];
         exp_q[i] = CLR[i] ? 1'b0 : PRE[i] ? 1'b1 : g[i];
      end
      mism = BUSY ? (DUT_Q ^ exp_q) : '0;
      for (int i = 0; i < WIDTH; i++) pop = pop + 3'(mism[i]);
      err_sum = {1'b0, ERR_COUNT} + 17'(pop);
   end
   always_ff @(posedge CLK) begin
      if (RST || start_run) begin
         state          <= RST ? S_IDLE : S_INIT;
         ERR_COUNT      <= 16'h0000;
         FIRST_ERR_IDX  <= 16'hFFFF;
         FIRST_ERR_MASK <= '0;
         g              <= {WIDTH{INIT}};
         lfsr           <= SEED_EFF;
         idx            <= 16'h0000;
      end else if (BUSY) begin
         g         <= g_nx;
         ERR_COUNT <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
         // A nonzero mask marks the first error as captured for this run.
         if (|mism && !(|FIRST_ERR_MASK)) begin
            FIRST_ERR_IDX  <= idx;
            FIRST_ERR_MASK <= mism;
         end
         if (load) begin
            lfsr <= lfsr_nx;
            idx  <= idx + 16'd1;
         end
         state <= load ? S_RUN : (state == S_DRAIN) ? S_DONE : S_DRAIN;
      end
      D  <= (RST || !load) ? '0 : v_d;
      EN <= (RST || !load) ? '0 : v_en;
   end
`ifdef PP3_EQUIV_ASYNC_EN
   logic [WIDTH-1:0] v_clr, v_pre;
   always_comb begin
      v_clr = '0;
      v_pre = '0;
      for (int i = 0; i < WIDTH; i++) begin
         v_clr[i] = lfsr_nx[8+i] & lfsr_nx[12+i];
         v_pre[i] = lfsr_nx[12+i] & ~lfsr_nx[8+i] & lfsr_nx[i^1];
      end
   end
   always_ff @(posedge CLK) begin
      CLR <= (RST || !load) ? '0 : v_clr;
      PRE <= (RST || !load) ? '0 : v_pre;
   end
`else
   assign CLR = '0;
   assign PRE = '0;
`endif
endmodule
